// File: rtl/mem_request_arbiter_if.sv
// Shared core/RAM bus seen by the memory request arbiter.
// master = the arbiter itself; slave = the core and RAM around it.
interface mem_request_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Core fetch port
  logic              imem_req;
  logic [ADDR_W-1:0] imemaddr;
  logic [DATA_W-1:0] imemload;
  logic              iready;
  // Core data port
  logic              dmem_ren;
  logic              dmem_wen;
  logic [ADDR_W-1:0] dmemaddr;
  logic [DATA_W-1:0] dmemstore;
  logic [DATA_W-1:0] dmemload;
  logic              dready;
  // Shared RAM port
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic              ram_ren;
  logic              ram_wen;
  logic [DATA_W-1:0] ramload;
  logic              ram_ack;
  logic              bus_err;

  // Handshake: a core request (imem_req / dmem_ren / dmem_wen) is held until
  // its one-cycle iready/dready strobe; the RAM completes the access that is
  // enabled by ram_ren/ram_wen in the cycle it raises ram_ack.
  modport master (
    input  imem_req, imemaddr, dmem_ren, dmem_wen, dmemaddr, dmemstore,
    input  ramload, ram_ack,
    output imemload, iready, dmemload, dready,
    output ramaddr, ramstore, ram_ren, ram_wen, bus_err
  );

  modport slave (
    output imem_req, imemaddr, dmem_ren, dmem_wen, dmemaddr, dmemstore,
    output ramload, ram_ack,
    input  imemload, iready, dmemload, dready,
    input  ramaddr, ramstore, ram_ren, ram_wen, bus_err
  );
endinterface

// File: rtl/mem_request_arbiter.sv
// Arbitrates the core fetch and data ports onto one RAM port, data first,
// with a per-access timeout that aborts a stalled RAM access.
module mem_request_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  mem_request_arbiter_if.master   bus,
  output logic [1:0]              o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0] r_ramaddr, w_ramaddr_nxt;
  logic [DATA_W-1:0] r_ramstore, w_ramstore_nxt;
  logic              r_ram_ren, w_ram_ren_nxt;
  logic              r_ram_wen, w_ram_wen_nxt;
  logic [DATA_W-1:0] r_imemload, w_imemload_nxt;
  logic [DATA_W-1:0] r_dmemload, w_dmemload_nxt;
  logic              r_iready, w_iready_nxt;
  logic              r_dready, w_dready_nxt;
  logic              r_bus_err, w_bus_err_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_ramaddr  <= '0;
      r_ramstore <= '0;
      r_ram_ren  <= 1'b0;
      r_ram_wen  <= 1'b0;
      r_imemload <= '0;
      r_dmemload <= '0;
      r_iready   <= 1'b0;
      r_dready   <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ramaddr  <= w_ramaddr_nxt;
      r_ramstore <= w_ramstore_nxt;
      r_ram_ren  <= w_ram_ren_nxt;
      r_ram_wen  <= w_ram_wen_nxt;
      r_imemload <= w_imemload_nxt;
      r_dmemload <= w_dmemload_nxt;
      r_iready   <= w_iready_nxt;
      r_dready   <= w_dready_nxt;
      r_bus_err  <= w_bus_err_nxt;
    end
  end

  // Strobes are computed on the way into DONE so they are high only there.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_ramaddr_nxt  = r_ramaddr;
    w_ramstore_nxt = r_ramstore;
    w_ram_ren_nxt  = r_ram_ren;
    w_ram_wen_nxt  = r_ram_wen;
    w_imemload_nxt = r_imemload;
    w_dmemload_nxt = r_dmemload;
    w_iready_nxt   = 1'b0;
    w_dready_nxt   = 1'b0;
    w_bus_err_nxt  = 1'b0;

    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (bus.dmem_ren || bus.dmem_wen) begin
          // A simultaneous load and store request resolves to the store.
          w_ramaddr_nxt  = bus.dmemaddr;
          w_ramstore_nxt = bus.dmemstore;
          w_ram_wen_nxt  = bus.dmem_wen;
          w_ram_ren_nxt  = ~bus.dmem_wen;
          w_state_nxt    = DATA;
        end else if (bus.imem_req) begin
          w_ramaddr_nxt = bus.imemaddr;
          w_ram_ren_nxt = 1'b1;
          w_ram_wen_nxt = 1'b0;
          w_state_nxt   = FETCH;
        end
      end

      DATA, FETCH: begin
        if (bus.ram_ack) begin
          w_ram_ren_nxt = 1'b0;
          w_ram_wen_nxt = 1'b0;
          if (r_state == FETCH) begin
            w_imemload_nxt = bus.ramload;
            w_iready_nxt   = 1'b1;
          end else begin
            if (!r_ram_wen) w_dmemload_nxt = bus.ramload;
            w_dready_nxt = 1'b1;
          end
          w_state_nxt = DONE;
        end else if (r_cnt == LAST_CNT) begin
          // Timeout abort: the target load register reads back as zero.
          w_ram_ren_nxt = 1'b0;
          w_ram_wen_nxt = 1'b0;
          w_bus_err_nxt = 1'b1;
          if (r_state == FETCH) begin
            w_imemload_nxt = '0;
            w_iready_nxt   = 1'b1;
          end else begin
            if (!r_ram_wen) w_dmemload_nxt = '0;
            w_dready_nxt = 1'b1;
          end
          w_state_nxt = DONE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      DONE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.ramaddr  = r_ramaddr;
  assign bus.ramstore = r_ramstore;
  assign bus.ram_ren  = r_ram_ren;
  assign bus.ram_wen  = r_ram_wen;
  assign bus.imemload = r_imemload;
  assign bus.dmemload = r_dmemload;
  assign bus.iready   = r_iready;
  assign bus.dready   = r_dready;
  assign bus.bus_err  = r_bus_err;
  assign o_dbg_state  = r_state;

endmodule

// File: doc/mem_request_arbiter.md
Name: mem_request_arbiter

Overview:
- Sits directly upstream of the single-cycle core. It sources the instruction word and the load data, and produces the i_ready/d_ready strobes the core waits on.
- Arbitrates the core's instruction-fetch port (PC) and data port (load/store) onto one shared RAM port, using a request/acknowledge handshake.
- Data accesses take priority over fetches. A per-access timeout counter prevents a stalled RAM from hanging the core.

Parameters:
- ADDR_W, 32, address width of core and RAM ports
- DATA_W, 32, data width of all data buses
- TIMEOUT, 255, cycles waited for ram_ack before aborting an access (1..2^16-1)

Ports:
- clk  input  1  system clock
- rst  input  1  reset
- imem_req  input  1  fetch request, held until iready
- imemaddr  input  ADDR_W  fetch address (PC)
- imemload  output  DATA_W  last fetched instruction word
- iready  output  1  one-cycle strobe: fetch complete
- dmem_ren  input  1  load request, held until dready
- dmem_wen  input  1  store request, held until dready
- dmemaddr  input  ADDR_W  load/store address (ALU result)
- dmemstore  input  DATA_W  store data
- dmemload  output  DATA_W  last load data
- dready  output  1  one-cycle strobe: data access complete
- ramaddr  output  ADDR_W  RAM address
- ramstore  output  DATA_W  RAM write data
- ram_ren  output  1  RAM read enable
- ram_wen  output  1  RAM write enable
- ramload  input  DATA_W  RAM read data, valid with ram_ack
- ram_ack  input  1  RAM completes the current access this cycle
- bus_err  output  1  one-cycle strobe: access aborted by timeout

Behaviour:
- One clock; reset is synchronous and active-high. rst is sampled on the clk rising edge and overrides all other inputs.
- All outputs are registered. Reset values:
  - all outputs 0, including imemload and dmemload
  - state IDLE, timeout counter 0
- States: IDLE, DATA, FETCH, DONE.
- IDLE:
  - If dmem_ren or dmem_wen: latch dmemaddr/dmemstore into ramaddr/ramstore, set ram_wen=dmem_wen and ram_ren=~dmem_wen, go to DATA.
  - Else if imem_req: latch imemaddr into ramaddr, set ram_ren=1 and ram_wen=0, go to FETCH.
  - Else stay in IDLE.
- Both dmem_ren and dmem_wen asserted: the store wins (ram_wen=1, ram_ren=0).
- DATA and FETCH:
  - RAM outputs are held stable; the counter increments every cycle.
  - On ram_ack: drop ram_ren/ram_wen and go to DONE. A load or fetch also captures ramload into dmemload or imemload respectively; a store leaves dmemload unchanged.
  - If the counter reaches TIMEOUT-1 without ram_ack: drop the enables, capture 0 into the target load register, set bus_err=1 for the DONE cycle, go to DONE.
  - ram_ack and timeout in the same cycle: ram_ack wins and bus_err stays 0.
- DONE (exactly 1 cycle):
  - iready=1 if the access was a fetch, dready=1 if it was data; counter cleared; go to IDLE.
  - Requests are ignored in this cycle. The requester must drop or replace its request by the cycle after the strobe.
- Latency: request first seen in IDLE at cycle 0; RAM enables valid from cycle 1; ram_ack at cycle k (k>=1); strobe at cycle k+1. Minimum round trip is 3 cycles, back-to-back accesses included.
- Ignored inputs: ram_ack in IDLE or DONE; request changes while in DATA or FETCH (the latched values are used).
- imemload and dmemload hold their value until the next completion of the same type.
- rst during DATA or FETCH: enables drop on the same edge, state returns to IDLE, no strobe is issued.

Test Plan:
- Fetch only: imem_req=1, imemaddr=0x0000_0040; RAM acks on the 2nd cycle of ram_ren with ramload=0x0050_0093 -> ramaddr=0x40, iready pulses once at cycle 3, imemload=0x0050_0093, dready=0.
- Priority: imem_req=1 and dmem_ren=1 (dmemaddr=0x100) in IDLE together -> DATA access first, dready and dmemload=ramload; on the next IDLE the fetch is issued and iready follows.
- Store: dmem_wen=1, dmemaddr=0x200, dmemstore=0xDEAD_BEEF; ack after 4 cycles -> ram_wen=1 for those 4 cycles, ramstore=0xDEAD_BEEF, dready pulses, dmemload unchanged.
- Timeout: TIMEOUT=8, ram_ack never asserted -> enables drop after 8 cycles, dready and bus_err pulse together, dmemload=0. Repeat with ram_ack on the timeout cycle -> bus_err=0, ramload captured.
- Reset mid-op: rst=1 during FETCH cycle 2 -> ram_ren=0 and all outputs 0 the next cycle, no iready, state IDLE; a fresh request after reset completes normally.
- Held request: core keeps imem_req high through DONE -> no extra access starts in DONE; a new fetch starts from IDLE one cycle later.
